// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencing for the 5-stage core
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush_req,
   input  logic             Branch_taken,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_RegisterRd,
   input  logic [4:0]       IF_ID_RegisterRs,
   input  logic [4:0]       IF_ID_RegisterRt,
   input  logic             EX_MEM_MemRead,
   input  logic             EX_MEM_MemWrite,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             ID_EX_Write,
   output logic             EX_MEM_Write,
   output logic             IF_Flush,
   output logic             ID_Flush,
   output logic             EX_Flush,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam int WCW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] TMO = WCW'(MEM_TIMEOUT);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t         state, state_nx;
   logic [WCW-1:0] wait_cnt, wait_nx;
   logic           err_set, apply_hz, mem_op, lu;

   assign mem_op = EX_MEM_MemRead | EX_MEM_MemWrite;
   assign lu     = ID_EX_MemRead && (ID_EX_RegisterRd != 5'd0) &&
                   ((ID_EX_RegisterRd == IF_ID_RegisterRs) ||
                    (ID_EX_RegisterRd == IF_ID_RegisterRt));

   always_comb begin
      mem_req      = 1'b0;
      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Write  = 1'b1;
      EX_MEM_Write = 1'b1;
      IF_Flush     = 1'b0;
      ID_Flush     = 1'b0;
      EX_Flush     = 1'b0;
      state_nx     = state;
      wait_nx      = wait_cnt;
      err_set      = 1'b0;
      apply_hz     = 1'b0;
      case (state)
         RUN: begin
            if (flush_req) begin
               IF_Flush = 1'b1;
               ID_Flush = 1'b1;
               EX_Flush = 1'b1;
            end else if (mem_op && !mem_ready) begin
               mem_req      = 1'b1;
               PC_Write     = 1'b0;
               IF_ID_Write  = 1'b0;
               ID_EX_Write  = 1'b0;
               EX_MEM_Write = 1'b0;
               state_nx     = MEM_WAIT;
               wait_nx      = WCW'(1);
            end else begin
               mem_req  = mem_op;
               apply_hz = 1'b1;
            end
         end
         default: begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            if (mem_ready) begin
               mem_req      = 1'b1;
               PC_Write     = 1'b1;
               IF_ID_Write  = 1'b1;
               ID_EX_Write  = 1'b1;
               EX_MEM_Write = 1'b1;
               apply_hz     = 1'b1;
               state_nx     = RUN;
               wait_nx      = '0;
            end else if (wait_cnt < TMO) begin
               mem_req = 1'b1;
               wait_nx = wait_cnt + WCW'(1);
            end else begin
               EX_Flush = 1'b1;
               err_set  = 1'b1;
               state_nx = RUN;
               wait_nx  = '0;
            end
         end
      endcase
      // A load-use stall holds IF/ID, so a concurrent branch is retried next cycle
      if (apply_hz) begin
         if (lu) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_Flush    = 1'b1;
         end else if (Branch_taken) begin
            IF_Flush = 1'b1;
         end
      end
      if (!reset_n) begin
         mem_req      = 1'b0;
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Write  = 1'b0;
         EX_MEM_Write = 1'b0;
         IF_Flush     = 1'b0;
         ID_Flush     = 1'b0;
         EX_Flush     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= RUN;
         wait_cnt  <= '0;
         mem_error <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         if (err_set)
            mem_error <= 1'b1;
         if (!PC_Write && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. Each cycle it generates the write-enable and flush controls for PC, IF/ID, ID/EX and EX/MEM from three sources, in priority order:
- data-memory wait handshake (including timeout abort)
- load-use hazards
- taken branches

It also keeps a sticky memory-error flag and a saturating stall-cycle counter. It sits beside the pipeline registers and drives EX/MEM's `EX_Flush` and write-enable.

## Interface
Parameters:
- `MEM_TIMEOUT`, 15: max MEM_WAIT cycles before abort (1..255).
- `CNT_W`, 16: stall counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `flush_req` in 1: external full flush (exception).
- `Branch_taken` in 1: branch resolved taken in ID.
- `ID_EX_MemRead` in 1: load in EX.
- `ID_EX_RegisterRd` in 5: load destination in EX.
- `IF_ID_RegisterRs`, `IF_ID_RegisterRt` in 5 each: ID source registers.
- `EX_MEM_MemRead`, `EX_MEM_MemWrite` in 1 each: access in MEM.
- `mem_ready` in 1: data memory completes the access this cycle.
- `mem_req` out 1: data memory request.
- `PC_Write`, `IF_ID_Write`, `ID_EX_Write`, `EX_MEM_Write` out 1 each: stage enables.
- `IF_Flush`, `ID_Flush`, `EX_Flush` out 1 each: clear IF/ID, insert bubble into ID/EX, clear EX/MEM control.
- `mem_error` out 1: sticky timeout flag.
- `stall_cnt` out CNT_W: saturating count of cycles with `PC_Write`=0.

## Operation
States:
- RUN: normal flow.
- MEM_WAIT: the pipeline is frozen on an outstanding access.

Definitions:
- `mem_op` = `EX_MEM_MemRead` | `EX_MEM_MemWrite`.
- `lu` = `ID_EX_MemRead` & (`ID_EX_RegisterRd`≠0) & (`ID_EX_RegisterRd`==`IF_ID_RegisterRs` | `ID_EX_RegisterRd`==`IF_ID_RegisterRt`).
- Defaults: all enables 1, all flushes 0, `mem_req`=0.

RUN, first matching rule wins:
1. `flush_req`: `IF_Flush`=`ID_Flush`=`EX_Flush`=1, enables 1, `mem_req`=0. Stay in RUN.
2. `mem_op` & !`mem_ready`: `mem_req`=1, all four enables 0. Next state MEM_WAIT, `wait_cnt`<=1.
3. `mem_op` & `mem_ready`: `mem_req`=1, defaults otherwise; evaluate rules 4-5 as well.
4. `lu`: `PC_Write`=`IF_ID_Write`=0, `ID_Flush`=1. Suppresses `IF_Flush` from a simultaneous `Branch_taken`; the branch is re-evaluated next cycle from the held IF/ID.
5. `Branch_taken` (no `lu`): `IF_Flush`=1.

MEM_WAIT:
- `flush_req` is ignored until the state returns to RUN.
- Every cycle: `mem_req`=1 and all four enables 0, except on the abort cycle.
- `mem_ready`: enables return to 1 and `mem_req`=1 in the same cycle. Next state RUN, `wait_cnt`<=0. `lu`/`Branch_taken` are applied as in RUN rules 4-5.
- !`mem_ready` & `wait_cnt`<`MEM_TIMEOUT`: `wait_cnt`++.
- !`mem_ready` & `wait_cnt`==`MEM_TIMEOUT` (abort): `mem_req`=0, `EX_Flush`=1, other enables stay 0. `mem_error`<=1, next state RUN, `wait_cnt`<=0.

Registers and widths:
- `wait_cnt` is $clog2(`MEM_TIMEOUT`+1) bits wide.
- `stall_cnt` increments on every rising edge where `PC_Write`=0 and `reset_n`=1. It saturates at all-ones and never wraps.
- `mem_error` clears only on reset.

## Timing
- Reset (`reset_n`=0, async):
  - Registers: state=RUN, `wait_cnt`=0, `mem_error`=0, `stall_cnt`=0.
  - Outputs are forced combinationally while reset is low: all enables 0, all flushes 0, `mem_req`=0.
- Reset asserted mid-MEM_WAIT abandons the access immediately. There is no abort cycle and no `mem_error`.
- All outputs except `mem_error`/`stall_cnt` are combinational from state plus current inputs (same-cycle response). `mem_error` and `stall_cnt` are registered: 1-cycle latency.
- Zero-wait access (`mem_ready` in the first cycle): no stall.
- N-cycle access (`mem_ready` in cycle N, N≥2): N-1 frozen cycles.
- Timeout: the abort occurs in the cycle where `wait_cnt`==`MEM_TIMEOUT`, i.e. `MEM_TIMEOUT`+1 cycles after first request. `mem_error` is visible the next cycle.
- `lu` stall lasts exactly one cycle per hazard: the bubble clears `ID_EX_MemRead`.

## Test plan
- Load-use: ID_EX load Rd=5, IF_ID Rs=5 → for 1 cycle `PC_Write`=`IF_ID_Write`=0, `ID_Flush`=1. Rd=0 → no stall.
- Branch alone → `IF_Flush`=1 for 1 cycle. Branch together with `lu` → `IF_Flush`=0, stall; next cycle `IF_Flush`=1.
- Load with `mem_ready` on the 3rd cycle → `mem_req`=1 for 3 cycles, enables 0 for 2 cycles, `stall_cnt`=2.
- `mem_ready` never arrives, `MEM_TIMEOUT`=15:
  - `mem_req` high for 15 cycles, then abort cycle: `EX_Flush`=1, `mem_req`=0.
  - `mem_error`=1 afterwards and held; back in RUN.
- `flush_req` in RUN with `mem_op` pending → three flushes=1, `mem_req`=0. `flush_req` in MEM_WAIT → ignored.
- `reset_n` low mid-MEM_WAIT → outputs zero immediately. After release: RUN, counters 0. Stall-counter saturation tested with `CNT_W`=4 → holds 15.
